// File: rtl/clock_pkg.sv
// Shared clocking types and widths for the PLL reset sequencer and its clock-enable dividers.
package clock_pkg;

  localparam int unsigned CE_DIV_W   = 16;
  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RESET_HOLD,
    RUN
  } pll_seq_state_t;

endpackage

// File: rtl/clken_div.sv
// One clock-enable channel: divides the clock by div while run is high, emitting a one-cycle ce strobe.
module clken_div
  import clock_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  input  logic [CE_DIV_W-1:0] div,
  output logic                ce
);

  logic [CE_DIV_W-1:0] cnt_q, cnt_d;
  logic                ce_q, ce_d;
  logic                hit_c;

  // Divisors 0 and 1 both mean "strobe every cycle".
  always_comb begin
    hit_c = (div <= CE_DIV_W'(1)) || (cnt_q == div - CE_DIV_W'(1));
    cnt_d = '0;
    ce_d  = 1'b0;
    if (run) begin
      ce_d  = hit_c;
      cnt_d = hit_c ? '0 : cnt_q + CE_DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns raw PLL lock into a debounced system reset plus divided clock-enable strobes.
// Define PLL_LOCK_LOSS_COUNT_EN to add the saturating lock_loss_count output.
module pll_reset_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned                       SYNC_STAGES  = 2,
  parameter int unsigned                       LOCK_CYCLES  = 1024,
  parameter int unsigned                       RESET_CYCLES = 16,
  parameter int unsigned                       NUM_CE       = 2,
  parameter logic [CE_DIV_W*NUM_CE-1:0]        CE_DIV       = {16'd24000, 16'd24}
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pll_locked,
  output logic                  sys_reset,
  output logic                  sys_ready,
  output logic [NUM_CE-1:0]     ce
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
`endif
);

  localparam int unsigned MAX_CYC = (LOCK_CYCLES > RESET_CYCLES) ? LOCK_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("LOCK_CYCLES must be >= 1");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset
    $error("RESET_CYCLES must be >= 1");
  end
  if (NUM_CE < 1) begin : g_bad_ce
    $error("NUM_CE must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  pll_seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   sys_ready_q, sys_ready_d;
  logic                   run_c;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loss of synchronised lock overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
        STABLE: begin
          if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RESET_HOLD: begin
          if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN:     cnt_d = '0;
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    run_c       = (state_q == RUN);
    sys_reset_d = !run_c;
    sys_ready_d = run_c;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sys_reset_q <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      sys_reset_q <= sys_reset_d;
      sys_ready_q <= sys_ready_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign sys_ready = sys_ready_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Counts forced drops back to WAIT_LOCK, saturating; only resetn clears it.
  always_comb begin
    loss_d = loss_q;
    if (!lock_s && (state_q != WAIT_LOCK) && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_count = loss_q;
`endif

  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    clken_div u_clken_div (
      .clock  (clock),
      .resetn (resetn),
      .run    (run_c),
      .div    (CE_DIV[CE_DIV_W*i +: CE_DIV_W]),
      .ce     (ce[i])
    );
  end

endmodule
